// File: rtl/dff_sipo_pkg.sv
// Shared types and sizing helpers for the SIPO receiver.
package dff_sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Bit counter width: must be able to hold the value WIDTH.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Enable-gated bit counter: clear takes priority over the current count, inc adds one.
module sipo_bit_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // clear together with inc loads 1, which is how a frame restart counts its first bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (en)
      count <= (clear ? '0 : count) + W'(inc);
  end

endmodule

// File: rtl/dff_sipo_receiver.sv
// Serial-in/parallel-out receiver with a registered valid/ready word buffer.
// Define DFF_SIPO_PARITY_EN to expect one even-parity bit after each data word.
module dff_sipo_receiver
  import dff_sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sdata,
  input  logic             sof,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CNT_W = cnt_w(WIDTH);
`ifdef DFF_SIPO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, shift_nxt, word;
  logic [CNT_W-1:0] count;
  logic             restart, take_bit, bit_last;
  logic             sreg_ld, cnt_en, cnt_clr, cnt_inc, complete;

  // sof restarts a frame from IDLE or mid-word, but never on the parity bit.
  assign restart  = enable && sof && (state != PARITY);
  assign take_bit = enable && ((state == SHIFT) || restart);
  assign bit_last = restart ? (WIDTH == 1) : (count == CNT_W'(WIDTH - 1));

  always_comb begin
    shift_nxt = restart ? '0 : sreg;
    if (MSB_FIRST) begin
      shift_nxt    = shift_nxt << 1;
      shift_nxt[0] = sdata;
    end else begin
      shift_nxt          = shift_nxt >> 1;
      shift_nxt[WIDTH-1] = sdata;
    end
  end

  sipo_bit_counter #(.W(CNT_W)) u_bit_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (cnt_en),
    .clear   (cnt_clr),
    .inc     (cnt_inc),
    .count   (count)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, SHIFT: if (take_bit) state_nxt = bit_last ? (PARITY_EN ? PARITY : IDLE) : SHIFT;
      PARITY:      if (enable)   state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    sreg_ld  = 1'b0;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    complete = 1'b0;
    word     = shift_nxt;
    if (take_bit) begin
      sreg_ld  = 1'b1;
      cnt_en   = 1'b1;
      cnt_clr  = restart || bit_last;
      cnt_inc  = !bit_last;
      complete = bit_last && !PARITY_EN;
    end else if ((state == PARITY) && enable) begin
      complete = 1'b1;
      word     = sreg;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      sreg <= '0;
    else if (sreg_ld)
      sreg <= shift_nxt;
  end

  // A completed word is only taken when the buffer is empty or being drained this edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (complete) begin
      if (!valid || ready) begin
        data  <= word;
        valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

`ifdef DFF_SIPO_PARITY_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      parity_err <= 1'b0;
    else if (complete && (!valid || ready))
      parity_err <= ^{sreg, sdata};
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
